mac_learning_table: RTL

Parametrised MAC address learning and forwarding-lookup table for the switch core. It is the successor to the fixed per-port wiring at the switch top level. For each frame header it returns an egress port mask, and it learns the source address against its ingress port. Entries age out on an external tick, and the table can be flushed. It sits between the per-port receive parsers and the switch fabric's egress scheduler, in the single system clock domain.

---
 rtl/mac_learning_table.sv | 196 +++++++++++++++++++
 1 files changed

// File: rtl/mac_learning_table.sv
// MAC address learning / forwarding-lookup table.
// Fully associative, aged entries, three-state lookup pipeline (IDLE/MATCH/RESP).
module mac_learning_table #(
  parameter  int PORT_NUMBER = 4,
  parameter  int TABLE_DEPTH = 16,
  parameter  int AGE_LIMIT   = 3,
  localparam int PW          = (PORT_NUMBER > 2) ? $clog2(PORT_NUMBER) : 1,
  localparam int CW          = $clog2(TABLE_DEPTH + 1)
) (
  input  logic                   clock,
  input  logic                   rst_n,
  input  logic                   lookup_valid,
  output logic                   lookup_ready,
  input  logic [47:0]            lookup_dst_mac,
  input  logic [47:0]            lookup_src_mac,
  input  logic [PW-1:0]          lookup_src_port,
  output logic                   result_valid,
  output logic [PORT_NUMBER-1:0] result_port_mask,
  output logic                   result_hit,
  input  logic                   age_tick,
  input  logic                   flush,
  output logic [CW-1:0]          entry_count
);

  localparam int AW = $clog2(AGE_LIMIT + 1);
  localparam int IW = (TABLE_DEPTH > 2) ? $clog2(TABLE_DEPTH) : 1;

  typedef enum logic [1:0] {IDLE, MATCH, RESP} state_t;

  state_t state;
  state_t state_nxt;

  logic abort;
  logic accept;

  logic [47:0]   req_dst;
  logic [47:0]   req_src;
  logic [PW-1:0] req_port;

  logic [TABLE_DEPTH-1:0] ent_valid;
  logic [47:0]            ent_mac  [TABLE_DEPTH];
  logic [PW-1:0]          ent_port [TABLE_DEPTH];
  logic [AW-1:0]          ent_age  [TABLE_DEPTH];

  logic          dst_hit;
  logic [PW-1:0] dst_port;
  logic          src_hit;
  logic [IW-1:0] src_idx;
  logic          free_found;
  logic [IW-1:0] free_idx;
  logic [IW-1:0] vic_idx;
  logic [AW-1:0] vic_age;

  logic [PORT_NUMBER-1:0] flood_mask;
  logic [PORT_NUMBER-1:0] dec_mask;
  logic                   dec_hit;

  logic                   learn_en;
  logic [IW-1:0]          learn_idx;
  logic [TABLE_DEPTH-1:0] wr_sel;
  logic [TABLE_DEPTH-1:0] val_nxt;
  logic [AW-1:0]          age_nxt [TABLE_DEPTH];
  logic [CW-1:0]          count_nxt;

  assign abort  = ~rst_n | flush;
  assign accept = lookup_valid & lookup_ready;

  // FSM state register; reset and flush both return to IDLE
  always_ff @(posedge clock) begin
    if (abort) state <= IDLE;
    else       state <= state_nxt;
  end

  // FSM next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = MATCH;
      MATCH:   state_nxt = RESP;
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // FSM outputs
  always_comb begin
    lookup_ready = (state == IDLE) & rst_n & ~flush;
    result_valid = (state == RESP);
  end

  // Capture request fields on acceptance
  always_ff @(posedge clock) begin
    if (!rst_n) begin
      req_dst  <= '0;
      req_src  <= '0;
      req_port <= '0;
    end else if (accept) begin
      req_dst  <= lookup_dst_mac;
      req_src  <= lookup_src_mac;
      req_port <= lookup_src_port;
    end
  end

  // Parallel search: dst/src matches, lowest free slot, oldest entry (lowest index on tie)
  always_comb begin
    dst_hit    = 1'b0;
    dst_port   = '0;
    src_hit    = 1'b0;
    src_idx    = '0;
    free_found = 1'b0;
    free_idx   = '0;
    vic_idx    = '0;
    vic_age    = ent_age[0];
    for (int unsigned i = 0; i < TABLE_DEPTH; i++) begin
      if (ent_valid[i] && (ent_mac[i] == req_dst) && !dst_hit) begin
        dst_hit  = 1'b1;
        dst_port = ent_port[i];
      end
      if (ent_valid[i] && (ent_mac[i] == req_src) && !src_hit) begin
        src_hit = 1'b1;
        src_idx = IW'(i);
      end
      if (!ent_valid[i] && !free_found) begin
        free_found = 1'b1;
        free_idx   = IW'(i);
      end
      if ((i > 0) && (ent_age[i] > vic_age)) begin
        vic_idx = IW'(i);
        vic_age = ent_age[i];
      end
    end
  end

  // Forwarding decision from pre-learning table contents
  always_comb begin
    flood_mask = ~(PORT_NUMBER'(1) << req_port);
    dec_mask   = flood_mask;
    dec_hit    = 1'b0;
    if (!req_dst[40] && dst_hit) begin
      dec_hit  = 1'b1;
      dec_mask = (dst_port == req_port) ? '0 : (PORT_NUMBER'(1) << dst_port);
    end
  end

  // Next table state: learning write wins over aging for the written entry
  always_comb begin
    learn_en  = (state == MATCH) & ~abort & ~req_src[40];
    learn_idx = src_hit ? src_idx : (free_found ? free_idx : vic_idx);
    wr_sel    = '0;
    val_nxt   = ent_valid;
    count_nxt = '0;
    for (int unsigned i = 0; i < TABLE_DEPTH; i++) begin
      age_nxt[i] = ent_age[i];
      if (learn_en && (learn_idx == IW'(i))) begin
        wr_sel[i]  = 1'b1;
        val_nxt[i] = 1'b1;
        age_nxt[i] = '0;
      end else if (age_tick && ent_valid[i]) begin
        if (ent_age[i] == AW'(AGE_LIMIT)) val_nxt[i] = 1'b0;
        else                              age_nxt[i] = ent_age[i] + AW'(1);
      end
      count_nxt = count_nxt + CW'(val_nxt[i]);
    end
  end

  // Table and entry count registers
  always_ff @(posedge clock) begin
    if (abort) begin
      ent_valid   <= '0;
      entry_count <= '0;
      for (int unsigned i = 0; i < TABLE_DEPTH; i++) ent_age[i] <= '0;
    end else begin
      ent_valid   <= val_nxt;
      entry_count <= count_nxt;
      for (int unsigned i = 0; i < TABLE_DEPTH; i++) begin
        ent_age[i] <= age_nxt[i];
        if (wr_sel[i]) begin
          ent_mac[i]  <= req_src;
          ent_port[i] <= req_port;
        end
      end
    end
  end

  // Result registers, updated at the end of MATCH and held afterwards
  always_ff @(posedge clock) begin
    if (!rst_n) begin
      result_port_mask <= '0;
      result_hit       <= 1'b0;
    end else if ((state == MATCH) && !flush) begin
      result_port_mask <= dec_mask;
      result_hit       <= dec_hit;
    end
  end

endmodule
